// File: rtl/multi_port_rob_pkg.sv
// Shared default sizing for the multi-port reorder buffer and its helpers.
package multi_port_rob_pkg;

  localparam int unsigned DEF_ROB_NUM   = 64;
  localparam int unsigned DEF_ROB_SEL   = 6;
  localparam int unsigned DEF_DP_WIDTH  = 2;
  localparam int unsigned DEF_COM_WIDTH = 2;
  localparam int unsigned DEF_FIN_PORTS = 4;
  localparam int unsigned DEF_REG_SEL   = 5;
  localparam int unsigned DEF_ADDR_LEN  = 32;

endpackage

// File: rtl/rob_commit_select.sv
// Commit window selection: finds the in-order run of finished entries at the head.
module rob_commit_select
  import multi_port_rob_pkg::*;
#(
  parameter int unsigned ROB_NUM   = DEF_ROB_NUM,
  parameter int unsigned ROB_SEL   = DEF_ROB_SEL,
  parameter int unsigned COM_WIDTH = DEF_COM_WIDTH
) (
  input  logic [ROB_NUM-1:0]                 valid,
  input  logic [ROB_NUM-1:0]                 finish,
  input  logic [ROB_NUM-1:0]                 dstvalid,
  input  logic [ROB_SEL-1:0]                 head,
  output logic [COM_WIDTH-1:0]               ready,
  output logic [COM_WIDTH-1:0]               arfwe,
  output logic [$clog2(COM_WIDTH + 1)-1:0]   comnum
);

  localparam int unsigned NUM_W = $clog2(COM_WIDTH + 1);

  // Prefix chain: a slot is ready only if every older slot in the window is ready
  always_comb begin
    logic               chain;
    logic [ROB_SEL-1:0] idx;
    chain  = 1'b1;
    idx    = '0;
    ready  = '0;
    arfwe  = '0;
    comnum = '0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      idx      = head + ROB_SEL'(k);
      chain    = chain & valid[idx] & finish[idx];
      ready[k] = chain;
      arfwe[k] = chain & dstvalid[idx];
      comnum   = comnum + NUM_W'(chain);
    end
  end

endmodule

// File: rtl/multi_port_rob.sv
// Multi-port reorder buffer: in-order dispatch, out-of-order completion, in-order commit.
module multi_port_rob
  import multi_port_rob_pkg::*;
#(
  parameter int unsigned ROB_NUM   = DEF_ROB_NUM,
  parameter int unsigned ROB_SEL   = DEF_ROB_SEL,
  parameter int unsigned DP_WIDTH  = DEF_DP_WIDTH,
  parameter int unsigned COM_WIDTH = DEF_COM_WIDTH,
  parameter int unsigned FIN_PORTS = DEF_FIN_PORTS,
  parameter int unsigned REG_SEL   = DEF_REG_SEL,
  parameter int unsigned ADDR_LEN  = DEF_ADDR_LEN
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic [DP_WIDTH-1:0]                dp_req_i,
  input  logic [DP_WIDTH*ADDR_LEN-1:0]       dp_pc_i,
  input  logic [DP_WIDTH-1:0]                dp_dstvalid_i,
  input  logic [DP_WIDTH*REG_SEL-1:0]        dp_dst_i,
  output logic                               dp_ready_o,
  output logic [DP_WIDTH*ROB_SEL-1:0]        dp_addr_o,
  input  logic [FIN_PORTS-1:0]               fin_valid_i,
  input  logic [FIN_PORTS*ROB_SEL-1:0]       fin_addr_i,
  output logic [COM_WIDTH-1:0]               com_valid_o,
  output logic [COM_WIDTH-1:0]               com_arfwe_o,
  output logic [COM_WIDTH*REG_SEL-1:0]       com_dst_o,
  output logic [COM_WIDTH*ADDR_LEN-1:0]      com_pc_o,
  output logic [$clog2(COM_WIDTH + 1)-1:0]   comnum_o,
  output logic [ROB_SEL-1:0]                 head_o,
  output logic [ROB_SEL:0]                   count_o,
  output logic                               empty_o,
  output logic                               full_o
);

  localparam int unsigned CNT_W  = ROB_SEL + 1;
  localparam int unsigned DPN_W  = $clog2(DP_WIDTH + 1);
  localparam int unsigned COMN_W = $clog2(COM_WIDTH + 1);

  logic [ROB_NUM-1:0]  valid_q, finish_q, dstvalid_q;
  logic [ROB_NUM-1:0]  valid_n, finish_n;
  logic [REG_SEL-1:0]  dst_q [ROB_NUM];
  logic [ADDR_LEN-1:0] pc_q  [ROB_NUM];
  logic [ROB_SEL-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]    count_q;

  logic [DP_WIDTH-1:0]  dp_acc;
  logic [DPN_W-1:0]     dp_num;
  logic [COM_WIDTH-1:0] com_rdy, com_rdy_we;
  logic [COMN_W-1:0]    com_rdy_num;

  // Credit is taken from registered occupancy only, so commits never free a slot early
  assign dp_ready_o = (count_q <= CNT_W'(ROB_NUM - DP_WIDTH));
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(ROB_NUM));
  assign head_o     = head_q;
  assign count_o    = count_q;

  rob_commit_select #(
    .ROB_NUM  (ROB_NUM),
    .ROB_SEL  (ROB_SEL),
    .COM_WIDTH(COM_WIDTH)
  ) u_commit_select (
    .valid   (valid_q),
    .finish  (finish_q),
    .dstvalid(dstvalid_q),
    .head    (head_q),
    .ready   (com_rdy),
    .arfwe   (com_rdy_we),
    .comnum  (com_rdy_num)
  );

  // Dispatch acceptance and entry addresses counted from the tail
  always_comb begin
    dp_acc    = dp_req_i & {DP_WIDTH{dp_ready_o & ~flush_i}};
    dp_num    = '0;
    dp_addr_o = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      dp_num = dp_num + DPN_W'(dp_acc[k]);
      dp_addr_o[k*ROB_SEL +: ROB_SEL] = tail_q + ROB_SEL'(k);
    end
  end

  // Commit outputs read straight from the head window; flush masks retirement
  always_comb begin
    logic [ROB_SEL-1:0] idx;
    idx         = '0;
    com_valid_o = com_rdy & {COM_WIDTH{~flush_i}};
    com_arfwe_o = com_rdy_we & {COM_WIDTH{~flush_i}};
    comnum_o    = flush_i ? '0 : com_rdy_num;
    com_dst_o   = '0;
    com_pc_o    = '0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      idx = head_q + ROB_SEL'(k);
      com_dst_o[k*REG_SEL +: REG_SEL]  = dst_q[idx];
      com_pc_o[k*ADDR_LEN +: ADDR_LEN] = pc_q[idx];
    end
  end

  // Next valid/finish: completions on live entries, then retire clears, then new allocations
  always_comb begin
    logic [ROB_SEL-1:0] idx;
    idx      = '0;
    valid_n  = valid_q;
    finish_n = finish_q;
    for (int p = 0; p < FIN_PORTS; p++) begin
      idx = fin_addr_i[p*ROB_SEL +: ROB_SEL];
      if (fin_valid_i[p] && valid_q[idx]) finish_n[idx] = 1'b1;
    end
    for (int k = 0; k < COM_WIDTH; k++) begin
      idx = head_q + ROB_SEL'(k);
      if (com_valid_o[k]) begin
        valid_n[idx]  = 1'b0;
        finish_n[idx] = 1'b0;
      end
    end
    for (int k = 0; k < DP_WIDTH; k++) begin
      idx = tail_q + ROB_SEL'(k);
      if (dp_acc[k]) begin
        valid_n[idx]  = 1'b1;
        finish_n[idx] = 1'b0;
      end
    end
  end

  // Control state: pointers, occupancy and per-entry status bits
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q  <= '0;
      finish_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      valid_q  <= '0;
      finish_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_n;
      finish_q <= finish_n;
      head_q   <= head_q + ROB_SEL'(comnum_o);
      tail_q   <= tail_q + ROB_SEL'(dp_num);
      count_q  <= count_q + CNT_W'(dp_num) - CNT_W'(comnum_o);
    end
  end

  // Payload capture on allocation; contents are meaningless until the entry is valid
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DP_WIDTH; k++) begin
      if (dp_acc[k]) begin
        pc_q[dp_addr_o[k*ROB_SEL +: ROB_SEL]]       <= dp_pc_i[k*ADDR_LEN +: ADDR_LEN];
        dst_q[dp_addr_o[k*ROB_SEL +: ROB_SEL]]      <= dp_dst_i[k*REG_SEL +: REG_SEL];
        dstvalid_q[dp_addr_o[k*ROB_SEL +: ROB_SEL]] <= dp_dstvalid_i[k];
      end
    end
  end

`ifndef SYNTHESIS
  // Interface protocol checks; a dropped dispatch or stray completion is reported, not fatal
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i) begin
      assert ((dp_req_i & (dp_req_i + DP_WIDTH'(1))) == '0)
        else $error("dp_req_i not prefix-contiguous: %b", dp_req_i);
      assert (dp_ready_o || (dp_req_i == '0))
        else $warning("dispatch request dropped while dp_ready_o is low");
      for (int p = 0; p < FIN_PORTS; p++) begin
        if (fin_valid_i[p]) begin
          assert (valid_q[fin_addr_i[p*ROB_SEL +: ROB_SEL]])
            else $warning("completion port %0d targets invalid entry %0d", p,
                          fin_addr_i[p*ROB_SEL +: ROB_SEL]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_port_rob.sv
// Directed bench for multi_port_rob: vector table plus multi-cycle corner sequences.
module tb_multi_port_rob;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic [1:0]  dp_req_i;
  logic [63:0] dp_pc_i;
  logic [1:0]  dp_dstvalid_i;
  logic [9:0]  dp_dst_i;
  logic        dp_ready_o;
  logic [11:0] dp_addr_o;
  logic [3:0]  fin_valid_i;
  logic [23:0] fin_addr_i;
  logic [1:0]  com_valid_o;
  logic [1:0]  com_arfwe_o;
  logic [9:0]  com_dst_o;
  logic [63:0] com_pc_o;
  logic [1:0]  comnum_o;
  logic [5:0]  head_o;
  logic [6:0]  count_o;
  logic        empty_o;
  logic        full_o;

  multi_port_rob dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .dp_req_i     (dp_req_i),
    .dp_pc_i      (dp_pc_i),
    .dp_dstvalid_i(dp_dstvalid_i),
    .dp_dst_i     (dp_dst_i),
    .dp_ready_o   (dp_ready_o),
    .dp_addr_o    (dp_addr_o),
    .fin_valid_i  (fin_valid_i),
    .fin_addr_i   (fin_addr_i),
    .com_valid_o  (com_valid_o),
    .com_arfwe_o  (com_arfwe_o),
    .com_dst_o    (com_dst_o),
    .com_pc_o     (com_pc_o),
    .comnum_o     (comnum_o),
    .head_o       (head_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] pcb;
    logic [1:0]  dv;
    logic [4:0]  d0, d1;
    logic [3:0]  fv;
    logic [23:0] fa;
    logic        e_rdy;
    logic [5:0]  e_addr0;
    logic [1:0]  e_cv, e_we, e_num;
    logic [5:0]  e_head;
    logic [6:0]  e_cnt;
    logic [4:0]  e_dst0;
    logic [31:0] e_pc0;
  } vec_t;

  vec_t tbl [14];
  int total = 0;
  int bad   = 0;

  function automatic logic [23:0] fa4(input logic [5:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    dp_req_i    = '0;
    flush_i     = 1'b0;
    fin_valid_i = '0;
  endtask

  task automatic set_dp(input logic [1:0] req, input logic [31:0] pcb, input logic [1:0] dv,
                        input logic [4:0] d0, input logic [4:0] d1);
    dp_req_i      = req;
    dp_pc_i       = {pcb + 32'd4, pcb};
    dp_dstvalid_i = dv;
    dp_dst_i      = {d1, d0};
  endtask

  task automatic finish_range(input int start, input int n);
    int a    = start;
    int left = n;
    while (left > 0) begin
      @(negedge clk_i); idle();
      for (int p = 0; p < 4; p++) begin
        if (left > 0) begin
          fin_valid_i[p]       = 1'b1;
          fin_addr_i[p*6 +: 6] = 6'(a);
          a = (a + 1) % 64;
          left--;
        end
      end
    end
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty_o && n < 200) begin
      @(negedge clk_i); idle(); #1;
      n++;
    end
    chk(name, 64'(empty_o), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b11, 32'h100, 2'b01, 5'd3,  5'd5, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd0, 2'b00, 2'b00, 2'd0, 6'd0, 7'd0, 5'd0,  32'h0};
    tbl[1]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0011, fa4(0,1,0,0), 1'b1, 6'd2, 2'b00, 2'b00, 2'd0, 6'd0, 7'd2, 5'd0,  32'h0};
    tbl[2]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd2, 2'b11, 2'b01, 2'd2, 6'd0, 7'd2, 5'd3,  32'h100};
    tbl[3]  = '{2'b11, 32'h200, 2'b11, 5'd6,  5'd7, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd2, 2'b00, 2'b00, 2'd0, 6'd2, 7'd0, 5'd0,  32'h0};
    tbl[4]  = '{2'b11, 32'h208, 2'b11, 5'd8,  5'd9, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd4, 2'b00, 2'b00, 2'd0, 6'd2, 7'd2, 5'd0,  32'h0};
    tbl[5]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0111, fa4(3,4,3,0), 1'b1, 6'd6, 2'b00, 2'b00, 2'd0, 6'd2, 7'd4, 5'd0,  32'h0};
    tbl[6]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd6, 2'b00, 2'b00, 2'd0, 6'd2, 7'd4, 5'd0,  32'h0};
    tbl[7]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0100, fa4(0,0,2,0), 1'b1, 6'd6, 2'b00, 2'b00, 2'd0, 6'd2, 7'd4, 5'd0,  32'h0};
    tbl[8]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd6, 2'b11, 2'b11, 2'd2, 6'd2, 7'd4, 5'd6,  32'h200};
    tbl[9]  = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd6, 2'b01, 2'b01, 2'd1, 6'd4, 7'd2, 5'd8,  32'h208};
    tbl[10] = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b1000, fa4(0,0,0,5), 1'b1, 6'd6, 2'b00, 2'b00, 2'd0, 6'd5, 7'd1, 5'd0,  32'h0};
    tbl[11] = '{2'b01, 32'h300, 2'b01, 5'd10, 5'd0, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd6, 2'b01, 2'b01, 2'd1, 6'd5, 7'd1, 5'd9,  32'h20c};
    tbl[12] = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0001, fa4(6,0,0,0), 1'b1, 6'd7, 2'b00, 2'b00, 2'd0, 6'd6, 7'd1, 5'd0,  32'h0};
    tbl[13] = '{2'b00, 32'h0,   2'b00, 5'd0,  5'd0, 4'b0000, fa4(0,0,0,0), 1'b1, 6'd7, 2'b01, 2'b01, 2'd1, 6'd6, 7'd1, 5'd10, 32'h300};

    reset_i = 1'b1;
    idle();
    dp_pc_i = '0; dp_dst_i = '0; dp_dstvalid_i = '0; fin_addr_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ready", 64'(dp_ready_o), 64'd1);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_head", 64'(head_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_cv", 64'(com_valid_o), 64'd0);
    chk("rst_num", 64'(comnum_o), 64'd0);
    reset_i = 1'b0;

    // Basic pair commit, out-of-order finish, same-cycle dispatch and commit
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i); idle();
      set_dp(tbl[i].req, tbl[i].pcb, tbl[i].dv, tbl[i].d0, tbl[i].d1);
      fin_valid_i = tbl[i].fv;
      fin_addr_i  = tbl[i].fa;
      #1;
      chk($sformatf("v%0d_rdy", i),   64'(dp_ready_o),      64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_addr0", i), 64'(dp_addr_o[5:0]),  64'(tbl[i].e_addr0));
      chk($sformatf("v%0d_cv", i),    64'(com_valid_o),     64'(tbl[i].e_cv));
      chk($sformatf("v%0d_we", i),    64'(com_arfwe_o),     64'(tbl[i].e_we));
      chk($sformatf("v%0d_num", i),   64'(comnum_o),        64'(tbl[i].e_num));
      chk($sformatf("v%0d_head", i),  64'(head_o),          64'(tbl[i].e_head));
      chk($sformatf("v%0d_cnt", i),   64'(count_o),         64'(tbl[i].e_cnt));
      if (tbl[i].e_cv[0]) begin
        chk($sformatf("v%0d_dst0", i), 64'(com_dst_o[4:0]),  64'(tbl[i].e_dst0));
        chk($sformatf("v%0d_pc0", i),  64'(com_pc_o[31:0]),  64'(tbl[i].e_pc0));
      end
    end

    // Fill to capacity from head = tail = 7
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i); idle(); #1;
      if (i == 31) begin
        chk("fill62_rdy", 64'(dp_ready_o), 64'd1);
        chk("fill62_cnt", 64'(count_o), 64'd62);
      end
      set_dp(2'b11, 32'h1000 + 32'(8 * i), 2'b11, 5'd1, 5'd2);
    end
    @(negedge clk_i); idle(); #1;
    chk("full_full", 64'(full_o), 64'd1);
    chk("full_rdy", 64'(dp_ready_o), 64'd0);
    chk("full_cnt", 64'(count_o), 64'd64);
    chk("full_empty", 64'(empty_o), 64'd0);
    dp_req_i = 2'b11;
    @(negedge clk_i); idle(); #1;
    chk("drop_cnt", 64'(count_o), 64'd64);
    chk("drop_tail", 64'(dp_addr_o[5:0]), 64'd7);
    fin_valid_i[0] = 1'b1; fin_addr_i[5:0] = 6'd7;
    @(negedge clk_i); idle(); #1;
    chk("full_num", 64'(comnum_o), 64'd1);
    chk("full_pc0", 64'(com_pc_o[31:0]), 64'h1000);
    @(negedge clk_i); idle(); #1;
    chk("c63_cnt", 64'(count_o), 64'd63);
    chk("c63_rdy", 64'(dp_ready_o), 64'd0);
    chk("c63_full", 64'(full_o), 64'd0);
    chk("c63_head", 64'(head_o), 64'd8);
    finish_range(8, 63);
    wait_empty("drain_empty");
    chk("drain_head", 64'(head_o), 64'd7);
    chk("drain_cnt", 64'(count_o), 64'd0);

    // Flush with 10 live entries, three finished at the head
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); idle();
      set_dp(2'b11, 32'h2000 + 32'(8 * i), 2'b11, 5'd4, 5'd5);
    end
    @(negedge clk_i); idle();
    fin_valid_i = 4'b0111; fin_addr_i = fa4(7, 8, 9, 0);
    @(negedge clk_i); idle();
    flush_i = 1'b1;
    set_dp(2'b11, 32'h2100, 2'b11, 5'd6, 5'd6);
    fin_valid_i = 4'b0001; fin_addr_i = fa4(10, 0, 0, 0);
    #1;
    chk("fl_cv", 64'(com_valid_o), 64'd0);
    chk("fl_we", 64'(com_arfwe_o), 64'd0);
    chk("fl_num", 64'(comnum_o), 64'd0);
    chk("fl_cnt_before", 64'(count_o), 64'd10);
    @(negedge clk_i); idle(); #1;
    chk("fl_cnt", 64'(count_o), 64'd0);
    chk("fl_empty", 64'(empty_o), 64'd1);
    chk("fl_head", 64'(head_o), 64'd0);
    chk("fl_addr0", 64'(dp_addr_o[5:0]), 64'd0);
    chk("fl_addr1", 64'(dp_addr_o[11:6]), 64'd1);
    set_dp(2'b01, 32'h500, 2'b01, 5'd1, 5'd0);
    @(negedge clk_i); idle(); #1;
    chk("pf_cnt", 64'(count_o), 64'd1);
    chk("pf_num", 64'(comnum_o), 64'd0);
    chk("pf_addr0", 64'(dp_addr_o[5:0]), 64'd1);
    flush_i = 1'b1;
    @(negedge clk_i); idle(); #1;
    chk("fl2_cnt", 64'(count_o), 64'd0);
    chk("fl2_addr0", 64'(dp_addr_o[5:0]), 64'd0);

    // Move both pointers to 62, then straddle the wrap point
    for (int i = 0; i < 31; i++) begin
      @(negedge clk_i); idle();
      set_dp(2'b11, 32'h3000 + 32'(8 * i), 2'b00, 5'd0, 5'd0);
    end
    finish_range(0, 62);
    wait_empty("pre_wrap_empty");
    chk("pre_wrap_head", 64'(head_o), 64'd62);
    @(negedge clk_i); idle();
    set_dp(2'b11, 32'h600, 2'b10, 5'd11, 5'd12);
    #1;
    chk("wr_addr0a", 64'(dp_addr_o[5:0]), 64'd62);
    chk("wr_addr1a", 64'(dp_addr_o[11:6]), 64'd63);
    @(negedge clk_i); idle();
    set_dp(2'b11, 32'h608, 2'b01, 5'd13, 5'd14);
    #1;
    chk("wr_addr0b", 64'(dp_addr_o[5:0]), 64'd0);
    chk("wr_addr1b", 64'(dp_addr_o[11:6]), 64'd1);
    @(negedge clk_i); idle();
    fin_valid_i = 4'b1111; fin_addr_i = fa4(62, 63, 0, 1);
    @(negedge clk_i); idle(); #1;
    chk("wr1_cv", 64'(com_valid_o), 64'd3);
    chk("wr1_we", 64'(com_arfwe_o), 64'd2);
    chk("wr1_pc0", 64'(com_pc_o[31:0]), 64'h600);
    chk("wr1_pc1", 64'(com_pc_o[63:32]), 64'h604);
    chk("wr1_dst1", 64'(com_dst_o[9:5]), 64'd12);
    chk("wr1_head", 64'(head_o), 64'd62);
    chk("wr1_cnt", 64'(count_o), 64'd4);
    @(negedge clk_i); idle(); #1;
    chk("wr2_cv", 64'(com_valid_o), 64'd3);
    chk("wr2_we", 64'(com_arfwe_o), 64'd1);
    chk("wr2_pc0", 64'(com_pc_o[31:0]), 64'h608);
    chk("wr2_pc1", 64'(com_pc_o[63:32]), 64'h60c);
    chk("wr2_head", 64'(head_o), 64'd0);
    chk("wr2_cnt", 64'(count_o), 64'd2);
    @(negedge clk_i); idle(); #1;
    chk("wr3_head", 64'(head_o), 64'd2);
    chk("wr3_empty", 64'(empty_o), 64'd1);

    // Asynchronous reset with five live entries, one committable
    @(negedge clk_i); idle();
    set_dp(2'b11, 32'h700, 2'b11, 5'd1, 5'd2);
    @(negedge clk_i); idle();
    set_dp(2'b11, 32'h708, 2'b11, 5'd3, 5'd4);
    @(negedge clk_i); idle();
    set_dp(2'b01, 32'h710, 2'b01, 5'd5, 5'd0);
    fin_valid_i[0] = 1'b1; fin_addr_i[5:0] = 6'd2;
    @(negedge clk_i); idle(); #1;
    chk("mr_cnt_pre", 64'(count_o), 64'd5);
    chk("mr_num_pre", 64'(comnum_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("mr_cnt", 64'(count_o), 64'd0);
    chk("mr_empty", 64'(empty_o), 64'd1);
    chk("mr_head", 64'(head_o), 64'd0);
    chk("mr_cv", 64'(com_valid_o), 64'd0);
    chk("mr_num", 64'(comnum_o), 64'd0);
    chk("mr_we", 64'(com_arfwe_o), 64'd0);
    chk("mr_rdy", 64'(dp_ready_o), 64'd1);
    chk("mr_full", 64'(full_o), 64'd0);
    @(negedge clk_i); #1;
    reset_i = 1'b0;
    chk("mr_tail", 64'(dp_addr_o[5:0]), 64'd0);
    @(negedge clk_i); idle();
    set_dp(2'b01, 32'h800, 2'b01, 5'd7, 5'd0);
    #1;
    chk("mr_new_addr", 64'(dp_addr_o[5:0]), 64'd0);
    @(negedge clk_i); idle(); #1;
    chk("mr_new_cnt", 64'(count_o), 64'd1);
    chk("mr_new_tail", 64'(dp_addr_o[5:0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_port_rob.md
Name: multi_port_rob

Overview:
- Parametrised reorder buffer for the superscalar core. Sits between dispatch and the ARF.
- Allocates up to DP_WIDTH entries per cycle in program order from its own tail pointer.
- Accepts completion from FIN_PORTS execution units.
- Retires up to COM_WIDTH consecutive finished entries per cycle from the head, driving ARF write-back. Supports a full pipeline flush.

Parameters:
- ROB_NUM, 64, number of entries (power of two, >= 2*DP_WIDTH).
- ROB_SEL, 6, entry index width = log2(ROB_NUM).
- DP_WIDTH, 2, dispatch slots per cycle.
- COM_WIDTH, 2, commit slots per cycle.
- FIN_PORTS, 4, execution-unit completion ports.
- REG_SEL, 5, architectural register index width.
- ADDR_LEN, 32, PC width.

Ports:
- clk_i in 1: clock; single clock domain.
- reset_i in 1: asynchronous, active-high reset.
- flush_i in 1: synchronous squash of all entries.
- dp_req_i in DP_WIDTH: dispatch request per slot; must be prefix-contiguous (slot k set implies slot k-1 set).
- dp_pc_i in DP_WIDTH*ADDR_LEN: PC per dispatch slot, slot 0 in LSBs.
- dp_dstvalid_i in DP_WIDTH: destination is valid per slot.
- dp_dst_i in DP_WIDTH*REG_SEL: destination register per slot.
- dp_ready_o out 1: free entries >= DP_WIDTH.
- dp_addr_o out DP_WIDTH*ROB_SEL: entry index assigned to each slot (tail+k mod ROB_NUM).
- fin_valid_i in FIN_PORTS: completion strobe per port.
- fin_addr_i in FIN_PORTS*ROB_SEL: entry index completed on each port.
- com_valid_o out COM_WIDTH: commit slot k retires this cycle.
- com_arfwe_o out COM_WIDTH: ARF write enable per commit slot.
- com_dst_o out COM_WIDTH*REG_SEL: destination register per commit slot.
- com_pc_o out COM_WIDTH*ADDR_LEN: PC per commit slot.
- comnum_o out clog2(COM_WIDTH+1): number of entries retired this cycle.
- head_o out ROB_SEL: current head (commit) pointer.
- count_o out ROB_SEL+1: current occupancy.
- empty_o out 1: count == 0.
- full_o out 1: count == ROB_NUM.

Behaviour:
- Storage: per-entry valid, finish, dstvalid, dst, pc. Pointers: head, tail (ROB_SEL bits, natural wrap). count is ROB_SEL+1 bits.
- Reset (async): valid = 0, finish = 0, head = 0, tail = 0, count = 0. Payload arrays are not reset.
- Outputs at reset: com_valid_o = 0, com_arfwe_o = 0, comnum_o = 0, dp_ready_o = 1, empty_o = 1, full_o = 0, head_o = 0, count_o = 0.
- Dispatch:
  - Slot k accepted when dp_req_i[k] & dp_ready_o & ~flush_i.
  - On acceptance, entry tail+k is written: valid = 1, finish = 0, payload captured.
  - tail advances by the number of accepted slots. dp_ready_o is registered-state only (no same-cycle commit credit).
  - A request while dp_ready_o = 0 is dropped with no state change; upstream must stall.
- Completion:
  - fin_valid_i[p] sets finish[fin_addr_i[p]] on the next edge, but only if that entry is valid.
  - Completion to an invalid entry is ignored.
  - Multiple ports hitting the same entry are harmless.
- Commit (combinational from registered state):
  - Slot k is ready when entry head+k is valid & finish AND slots 0..k-1 are ready (prefix chain).
  - com_valid_o = ready & ~flush_i.
  - com_arfwe_o[k] = com_valid_o[k] & dstvalid[head+k].
  - comnum_o = popcount(com_valid_o).
  - On the edge: valid and finish of retired entries are cleared; head += comnum_o.
- Same-cycle events:
  - An entry finished in cycle N commits no earlier than cycle N+1.
  - Dispatch and commit in the same cycle: count += accepted - comnum_o.
  - Dispatch never targets an entry being committed, because dp_ready_o uses registered count.
  - A fin_valid_i for an entry being committed is a don't-care; that entry is already finished.
- Flush:
  - flush_i forces com_valid_o, com_arfwe_o and comnum_o to 0 and suppresses dispatch.
  - On the edge: all valid and finish cleared; head = tail = 0; count = 0.
  - Completions in the flush cycle are discarded.
- Wrap-around: all index arithmetic is mod ROB_NUM. The commit window and dispatch addresses cross entry ROB_NUM-1 -> 0 seamlessly.
- Assertions (sim only):
  - dp_req_i not prefix-contiguous.
  - dispatch while ~dp_ready_o.
  - fin_addr_i pointing to an invalid entry.

Decomposition:
- Shared package (consts): ROB_NUM, ROB_SEL, REG_SEL, ADDR_LEN, DP_WIDTH, COM_WIDTH, FIN_PORTS defaults.
- Sub-module rob_commit_select: inputs are the valid/finish/dstvalid vectors and head; outputs are the ready prefix mask and comnum. This is pure combinational logic, reusable when COM_WIDTH changes.

Test Plan:
- Reset mid-operation with 5 entries live -> all outputs at reset values asynchronously; head = tail = 0; count = 0 after release.
- Dispatch 2 entries (pcs 0x100, 0x104, dst r3/r5, dstvalid 1/0) -> dp_addr_o = 0, 1; finish both in one cycle -> next cycle com_valid_o = 11, com_arfwe_o = 01, com_dst_o[0] = 3, comnum_o = 2, head = 2.
- Out-of-order finish: dispatch 4 entries, finish entries 1 and 2 first -> comnum_o = 0; then finish entry 0 -> commit 0 and 1, next cycle commit 2, then entry 3 after its finish.
- Fill to 64 entries -> full_o = 1, dp_ready_o = 0 from count 63; a dropped request leaves tail unchanged. Drain -> empty_o = 1.
- Wrap-around: set head = tail = 62, dispatch 4 entries -> addresses 62, 63, 0, 1; commit pairs retire across the boundary in order.
- flush_i with 10 live entries, some finished, plus a same-cycle dispatch and finish -> comnum_o = 0 that cycle; next cycle count = 0, empty_o = 1, new dispatch gets address 0.
